period_averager: RTL and testbench
==================================

// Module: period_averager
// PURPOSE
// - Downstream consumer of the periodic address generator: takes its addr/tvalid/restart stream plus one ADC sample per beat.
// - Accumulates the sample at each address over N consecutive periods into an internal accumulator RAM.
// - Host reads the result through a read port once ready is high.
// - Sits between the address generator / ADC front end and the AXI/BRAM readout path.
// PARAMETERS
// - WIDTH        8   word-address bits; RAM depth 2**WIDTH; addr is byte address (WIDTH+2 bits)
// - DATA_WIDTH   16  signed sample width
// - ACC_WIDTH    32  signed accumulator width
// - N_AVG_WIDTH  16  period counter width
// PORTS
// - clk        in   1            single clock
// - resetn     in   1            synchronous, active-low reset
// - addr       in   WIDTH+2      byte address from generator; word index = addr[WIDTH+1:2]
// - tvalid     in   1            beat valid; din/addr/restart sampled only when high
// - restart    in   1            high on the beat carrying word index 0 of a new period
// - din        in   DATA_WIDTH   signed sample, aligned with addr
// - avg_on     in   1            level: 1 = arm/run, 0 = abort to IDLE
// - n_avg_set  in   N_AVG_WIDTH  periods to average; 0 treated as 1; latched on arm
// - ready      out  1            results complete and stable
// - n_avg      out  N_AVG_WIDTH  periods accumulated so far
// - rd_addr    in   WIDTH        host read word index
// - rd_data    out  ACC_WIDTH    accumulator at rd_addr, 1-cycle latency, sign-extended
// BEHAVIOUR
// - Reset: state IDLE, ready=0, n_avg=0, pipeline valids 0, rd_data=0. RAM is not cleared.
// - FSM:
//   - IDLE -> ARMED when avg_on=1; n_avg_set is latched (0 -> 1).
//   - ARMED -> ACCUM on the first tvalid&restart beat; that beat is accumulated.
//   - ACCUM -> DRAIN on tvalid&restart when n_avg == target; the terminating beat is NOT accumulated.
//   - DRAIN -> DONE after 2 cycles, once the pipeline is empty.
//   - DONE -> IDLE when avg_on=0; DONE is held while avg_on=1.
//   - avg_on=0 in ARMED/ACCUM/DRAIN -> IDLE on the next cycle; in-flight writes are discarded; ready stays 0.
// - n_avg: cleared on arm; increments on each accepted restart in ARMED/ACCUM, saturating at target.
// - ready: 1 only in DONE. It rises 3 cycles after the terminating restart beat.
// - 3-stage pipeline:
//   - S0 registers addr/din/first flag.
//   - S1 reads RAM (1-cycle sync read).
//   - S2 computes the sum and writes.
//   - First period (n_avg==1): write = sext(din), overwriting stale contents. Later periods: write = RAM + sext(din).
// - Hazard: if the S2 write index equals the S1 read index in the same cycle, the S2 write data is forwarded. Periods of 1 or 2 words are correct.
// - tvalid low: bubble. No state change; gaps of any length are allowed.
// - Arithmetic: signed two's complement; default wraps modulo 2**ACC_WIDTH.
// - rd port: independent read port, usable in any state. Contents are defined only while ready=1.
// - restart with tvalid=0 is ignored.
// - restart with word index != 0 is taken as a period boundary anyway (no error flag).
// CONFIGURATION
// - PERIOD_AVERAGER_SAT_EN defined: S2 add saturates to [-2**(ACC_WIDTH-1), 2**(ACC_WIDTH-1)-1].
// - PERIOD_AVERAGER_SAT_EN undefined: plain wrapping add. Saturation logic is absent.
// TESTING
// - Reset: resetn=0 for 5 cycles mid-ACCUM -> ready=0, n_avg=0, state IDLE; arming again gives a correct result.
// - Nominal accumulation:
//   - Stimulus: WIDTH=8, period 256 words, din=word index, n_avg_set=4.
//   - Result: rd_data[k]=4*k for all k, n_avg=4.
//   - ready rises exactly 3 cycles after the 5th restart.
// - Hazard: period of 2 words, din=1, n_avg_set=10 -> rd_data[0]=rd_data[1]=10.
//   - Same check with a 1-word period -> rd_data[0]=10.
// - Abort: avg_on 1->0 after 2 periods -> IDLE next cycle, ready=0.
//   - Re-arm with n_avg_set=1, din=5 -> all words =5; stale data is overwritten.
// - Overflow: ACC_WIDTH=16, din=0x7FFF, n_avg_set=4.
//   - Without PERIOD_AVERAGER_SAT_EN: 0xFFFC.
//   - With PERIOD_AVERAGER_SAT_EN: 0x7FFF.
// - Gaps: tvalid randomly low 50% of cycles, same stimulus as nominal -> results identical to nominal.

Source files
------------

// File: rtl/period_averager.sv
// period_averager
//
// Averages a periodic sample stream coming from the periodic address generator.
// Each beat carries a byte address (word index = addr[WIDTH+1:2]) and one
// signed ADC sample. Over N consecutive periods the sample at each word index
// is summed into an internal accumulator RAM. The host reads the sums through
// an independent read port once ready is high.
//
// Ports:
//   clk        single clock
//   resetn     synchronous, active-low reset
//   addr       byte address from the generator (WIDTH+2 bits)
//   tvalid     beat valid; addr/din/restart are sampled only when high
//   restart    marks the first beat of a new period
//   din        signed sample aligned with addr
//   avg_on     level: 1 = arm/run, 0 = abort/return to idle
//   n_avg_set  number of periods to average (0 is treated as 1), latched on arm
//   ready      results complete and stable
//   n_avg      periods accumulated so far
//   rd_addr    host read word index
//   rd_data    accumulator at rd_addr, one cycle latency
//
// Configuration macro:
//   PERIOD_AVERAGER_SAT_EN  when defined, the accumulate add saturates instead
//                           of wrapping modulo 2**ACC_WIDTH.

module period_averager #(
  parameter int WIDTH       = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int ACC_WIDTH   = 32,
  parameter int N_AVG_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [WIDTH+1:0]       addr,
  input  logic                   tvalid,
  input  logic                   restart,
  input  logic [DATA_WIDTH-1:0]  din,
  input  logic                   avg_on,
  input  logic [N_AVG_WIDTH-1:0] n_avg_set,
  output logic                   ready,
  output logic [N_AVG_WIDTH-1:0] n_avg,
  input  logic [WIDTH-1:0]       rd_addr,
  output logic [ACC_WIDTH-1:0]   rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_ACCUM,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [N_AVG_WIDTH-1:0] target;
  logic                   drain_cnt;

  logic [WIDTH-1:0] beat_idx;
  logic             restart_beat;
  logic             at_target;
  logic             accept;
  logic             accept_first;

  // Byte-lane bits of the address carry no information for a word RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  assign beat_idx     = addr[WIDTH+1:2];
  assign restart_beat = tvalid & restart;
  assign at_target    = (n_avg == target);

  // Pipeline registers
  logic                         s0_valid, s1_valid, s2_valid;
  logic [WIDTH-1:0]             s0_idx, s1_idx, s2_idx;
  logic signed [DATA_WIDTH-1:0] s0_din, s1_din;
  logic                         s0_first, s1_first;
  logic signed [ACC_WIDTH-1:0]  s2_data;
  logic signed [ACC_WIDTH-1:0]  ram_q;

  logic [ACC_WIDTH-1:0] mem [0:(1<<WIDTH)-1];

  logic                        wr_en;
  logic signed [ACC_WIDTH-1:0] base;
  logic signed [ACC_WIDTH-1:0] addend;
  logic signed [ACC_WIDTH-1:0] sum;
  logic signed [ACC_WIDTH-1:0] wr_data;

  // Next-state logic plus beat acceptance. A beat is accumulated on the first
  // restart while armed, and on every beat while accumulating except the
  // restart that closes the final period. A beat belongs to the first period
  // (overwrite rather than add) when it is the arming restart itself or a
  // non-restart beat while n_avg is still 1.
  always_comb begin
    state_nxt    = state;
    accept       = 1'b0;
    accept_first = 1'b0;
    case (state)
      ST_IDLE: begin
        if (avg_on) state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (!avg_on) begin
          state_nxt = ST_IDLE;
        end else if (restart_beat) begin
          state_nxt    = ST_ACCUM;
          accept       = 1'b1;
          accept_first = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (!avg_on) begin
          state_nxt = ST_IDLE;
        end else if (restart_beat && at_target) begin
          state_nxt = ST_DRAIN;
        end else if (tvalid) begin
          accept       = 1'b1;
          accept_first = !restart && (n_avg == N_AVG_WIDTH'(1));
        end
      end
      ST_DRAIN: begin
        if (!avg_on)        state_nxt = ST_IDLE;
        else if (drain_cnt) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (!avg_on) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register, period target and period counter. The counter saturates
  // at the target so the closing restart leaves it at the requested count.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      target    <= N_AVG_WIDTH'(1);
      n_avg     <= '0;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == ST_DRAIN);
      if (state == ST_IDLE && avg_on) begin
        target <= (n_avg_set == '0) ? N_AVG_WIDTH'(1) : n_avg_set;
        n_avg  <= '0;
      end else if (avg_on && restart_beat && !at_target &&
                   (state == ST_ARMED || state == ST_ACCUM)) begin
        n_avg <= n_avg + N_AVG_WIDTH'(1);
      end
    end
  end

  assign ready = (state == ST_DONE);

  // Dropping avg_on kills every in-flight beat so nothing lands in the RAM
  // after an abort.
  assign wr_en = s1_valid & avg_on;

  // Pipeline valids and payloads: S0 captures the beat, S1 holds it while the
  // RAM read returns, S2 remembers the last write for forwarding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s0_idx   <= '0;
      s1_idx   <= '0;
      s2_idx   <= '0;
      s0_din   <= '0;
      s1_din   <= '0;
      s0_first <= 1'b0;
      s1_first <= 1'b0;
      s2_data  <= '0;
      rd_data  <= '0;
    end else begin
      s0_valid <= accept;
      if (accept) begin
        s0_idx   <= beat_idx;
        s0_din   <= din;
        s0_first <= accept_first;
      end
      s1_valid <= s0_valid & avg_on;
      s1_idx   <= s0_idx;
      s1_din   <= s0_din;
      s1_first <= s0_first;
      s2_valid <= wr_en;
      s2_idx   <= s1_idx;
      s2_data  <= wr_data;
      rd_data  <= mem[rd_addr];
    end
  end

  // Accumulator RAM: one write port, a pipeline read port and a host read
  // port. Contents are deliberately not reset; the first period overwrites.
  always_ff @(posedge clk) begin
    if (wr_en) mem[s1_idx] <= wr_data;
    ram_q <= mem[s0_idx];
  end

  // The RAM read for a beat happens on the same edge the previous beat is
  // written, so it returns the old value; when both beats hit the same word
  // (1-word periods) the just-written sum is taken from S2 instead.
  always_comb begin
    base   = (s2_valid && (s2_idx == s1_idx)) ? s2_data : ram_q;
    addend = ACC_WIDTH'(s1_din);
  end

`ifdef PERIOD_AVERAGER_SAT_EN
  logic signed [ACC_WIDTH:0] sum_w;

  // One guard bit detects signed overflow; clamp to the representable range.
  always_comb begin
    sum_w = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(addend);
    if (sum_w[ACC_WIDTH] != sum_w[ACC_WIDTH-1]) begin
      sum = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                             : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      sum = sum_w[ACC_WIDTH-1:0];
    end
  end
`else
  always_comb begin
    sum = base + addend;
  end
`endif

  assign wr_data = s1_first ? addend : sum;

endmodule

// File: tb/tb_period_averager.sv
// tb_period_averager
//
// Directed bench for period_averager. A default-parameter instance covers
// reset, nominal averaging, forwarding hazards, abort, and gapped input; a
// second instance with ACC_WIDTH=16 covers accumulator overflow (wrap or
// saturate depending on PERIOD_AVERAGER_SAT_EN).

module tb_period_averager;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  addr;
  logic        tvalid;
  logic        restart;
  logic [15:0] din;
  logic        avg_on;
  logic [15:0] n_avg_set;
  logic [7:0]  rd_addr;

  logic        ready;
  logic [15:0] n_avg;
  logic [31:0] rd_data;

  logic        ready_ovf;
  logic [15:0] n_avg_ovf;
  logic [15:0] rd_data_ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  period_averager #(
    .WIDTH(8), .DATA_WIDTH(16), .ACC_WIDTH(32), .N_AVG_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .addr(addr), .tvalid(tvalid),
    .restart(restart), .din(din), .avg_on(avg_on), .n_avg_set(n_avg_set),
    .ready(ready), .n_avg(n_avg), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  period_averager #(
    .WIDTH(2), .DATA_WIDTH(16), .ACC_WIDTH(16), .N_AVG_WIDTH(16)
  ) dut_ovf (
    .clk(clk), .resetn(resetn), .addr(addr[3:0]), .tvalid(tvalid),
    .restart(restart), .din(din), .avg_on(avg_on), .n_avg_set(n_avg_set),
    .ready(ready_ovf), .n_avg(n_avg_ovf), .rd_addr(rd_addr[1:0]),
    .rd_data(rd_data_ovf)
  );

  // Watchdog so the run always terminates.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One beat, optionally preceded by a random number of idle cycles.
  task automatic applyStimulus(input int idx, input logic [15:0] data,
                               input logic rs, input bit gaps);
    if (gaps) begin
      for (int g = 0; g < 8 && $urandom_range(1) == 0; g++) begin
        @(negedge clk);
        tvalid  = 1'b0;
        restart = 1'b0;
      end
    end
    @(negedge clk);
    tvalid  = 1'b1;
    restart = rs;
    addr    = 10'(idx << 2);
    din     = data;
  endtask

  // Return to idle, then arm with a new period count.
  task automatic armAverager(input logic [15:0] n);
    @(negedge clk);
    tvalid  = 1'b0;
    restart = 1'b0;
    avg_on  = 1'b0;
    @(negedge clk);
    n_avg_set = n;
    avg_on    = 1'b1;
  endtask

  // Feed whole periods, then the closing restart, and check ready rises
  // exactly three cycles after that restart.
  task automatic runAverage(input string tag, input int words, input int periods,
                            input bit use_const, input logic [15:0] cval,
                            input bit gaps);
    for (int p = 0; p < periods; p++)
      for (int w = 0; w < words; w++)
        applyStimulus(w, use_const ? cval : 16'(w), (w == 0), gaps);
    applyStimulus(0, 16'h0, 1'b1, gaps);
    @(negedge clk);
    tvalid  = 1'b0;
    restart = 1'b0;
    checkOutput({tag, "_ready_c1"}, 32'(ready), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ready_c2"}, 32'(ready), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_ready_c3"}, 32'(ready), 32'd1);
    checkOutput({tag, "_n_avg"}, 32'(n_avg), 32'(periods));
  endtask

  task automatic readWord(input int idx, output logic [31:0] v,
                          output logic [15:0] vo);
    @(negedge clk);
    rd_addr = 8'(idx);
    @(negedge clk);
    v  = rd_data;
    vo = rd_data_ovf;
  endtask

  initial begin
    logic [31:0] v;
    logic [15:0] vo;
    logic [31:0] ovf_exp;

    resetn    = 1'b0;
    addr      = '0;
    tvalid    = 1'b0;
    restart   = 1'b0;
    din       = '0;
    avg_on    = 1'b0;
    n_avg_set = '0;
    rd_addr   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_ready", 32'(ready), 32'd0);
    checkOutput("reset_n_avg", 32'(n_avg), 32'd0);
    checkOutput("reset_rd_data", rd_data, 32'd0);
    resetn = 1'b1;

    // Reset in the middle of accumulation
    armAverager(16'd4);
    for (int w = 0; w < 256; w++) applyStimulus(w, 16'(w), (w == 0), 1'b0);
    for (int w = 0; w < 10; w++)  applyStimulus(w, 16'(w), (w == 0), 1'b0);
    @(negedge clk);
    checkOutput("midrun_n_avg", 32'(n_avg), 32'd2);
    tvalid  = 1'b0;
    restart = 1'b0;
    avg_on  = 1'b0;
    resetn  = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midreset_ready", 32'(ready), 32'd0);
    checkOutput("midreset_n_avg", 32'(n_avg), 32'd0);
    resetn = 1'b1;

    // Nominal: 256-word period, din = word index, 4 periods
    $display("[TB] nominal accumulation");
    armAverager(16'd4);
    runAverage("nominal", 256, 4, 1'b0, 16'h0, 1'b0);
    for (int k = 0; k < 256; k++) begin
      readWord(k, v, vo);
      checkOutput("nominal_word", v, 32'(4 * k));
    end

    // Forwarding hazards: 2-word and 1-word periods, back to back
    $display("[TB] hazard periods");
    armAverager(16'd10);
    runAverage("hazard2", 2, 10, 1'b1, 16'd1, 1'b0);
    readWord(0, v, vo);
    checkOutput("hazard2_word0", v, 32'd10);
    readWord(1, v, vo);
    checkOutput("hazard2_word1", v, 32'd10);

    armAverager(16'd10);
    runAverage("hazard1", 1, 10, 1'b1, 16'd1, 1'b0);
    readWord(0, v, vo);
    checkOutput("hazard1_word0", v, 32'd10);

    // Abort after two periods, then re-arm with a single period
    $display("[TB] abort and re-arm");
    armAverager(16'd4);
    for (int p = 0; p < 2; p++)
      for (int w = 0; w < 256; w++) applyStimulus(w, 16'd7, (w == 0), 1'b0);
    @(negedge clk);
    tvalid  = 1'b0;
    restart = 1'b0;
    avg_on  = 1'b0;
    @(negedge clk);
    checkOutput("abort_ready", 32'(ready), 32'd0);
    @(negedge clk);
    checkOutput("abort_ready_hold", 32'(ready), 32'd0);
    armAverager(16'd1);
    runAverage("rearm", 256, 1, 1'b1, 16'd5, 1'b0);
    for (int k = 0; k < 256; k++) begin
      readWord(k, v, vo);
      checkOutput("rearm_word", v, 32'd5);
    end

    // Gapped input stream, same stimulus as nominal
    $display("[TB] gapped input");
    armAverager(16'd4);
    runAverage("gaps", 256, 4, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 256; k++) begin
      readWord(k, v, vo);
      checkOutput("gaps_word", v, 32'(4 * k));
    end

    // Overflow on the 16-bit accumulator instance
    $display("[TB] overflow");
`ifdef PERIOD_AVERAGER_SAT_EN
    ovf_exp = 32'h0000_7FFF;
`else
    ovf_exp = 32'h0000_FFFC;
`endif
    armAverager(16'd4);
    runAverage("ovf", 4, 4, 1'b1, 16'h7FFF, 1'b0);
    checkOutput("ovf_ready", 32'(ready_ovf), 32'd1);
    checkOutput("ovf_n_avg", 32'(n_avg_ovf), 32'd4);
    for (int k = 0; k < 4; k++) begin
      readWord(k, v, vo);
      checkOutput("ovf_wide_word", v, 32'h0001_FFFC);
      checkOutput("ovf_narrow_word", 32'(vo), ovf_exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
